// File: rtl/spi_tx_byte.sv
// SPI mode-0 byte transmitter; first bit on MOSI one cycle after acceptance, frame is 16*HALF cycles.
// No backpressure: en_tx is accepted only while idle, and requests seen while busy are dropped.
module spi_tx_byte #(
  parameter int HALF      = 5,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       en_tx,
  input  logic [7:0] tx_data,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int FRAME = 16 * HALF;
  localparam int CW    = $clog2(FRAME);
  localparam int PW    = $clog2(2 * HALF);

  localparam logic [CW-1:0] C_LAST = CW'(FRAME - 1);
  localparam logic [PW-1:0] P_RISE = PW'(HALF - 1);
  localparam logic [PW-1:0] P_FALL = PW'(2 * HALF - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [PW-1:0] ph, ph_nx;
  logic [7:0]    sreg, sreg_nx;
  logic [7:0]    load;
  logic          sclk_nx, mosi_nx, busy_nx, done_nx;

  // The shift register always sends bit 7 first, so LSB-first bytes are mirrored on load.
  always_comb begin
    load = tx_data;
    if (LSB_FIRST) begin
      for (int i = 0; i < 8; i++) load[i] = tx_data[7-i];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ph       <= '0;
      sreg     <= '0;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      ph       <= ph_nx;
      sreg     <= sreg_nx;
      spi_sclk <= sclk_nx;
      spi_mosi <= mosi_nx;
      tx_busy  <= busy_nx;
      tx_done  <= done_nx;
    end
  end

  // ph tracks the position within one SCLK period, so edge decisions avoid dividing cnt.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ph_nx    = ph;
    sreg_nx  = sreg;
    sclk_nx  = spi_sclk;
    mosi_nx  = spi_mosi;
    busy_nx  = tx_busy;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (en_tx) begin
          state_nx = SHIFT;
          sreg_nx  = load;
          cnt_nx   = '0;
          ph_nx    = '0;
          busy_nx  = 1'b1;
          mosi_nx  = load[7];
        end
      end
      SHIFT: begin
        cnt_nx = cnt + 1'b1;
        ph_nx  = (ph == P_FALL) ? '0 : ph + 1'b1;
        if (cnt == C_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          ph_nx    = '0;
          sclk_nx  = 1'b0;
          mosi_nx  = 1'b0;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end else if (ph == P_RISE) begin
          sclk_nx = 1'b1;
        end else if (ph == P_FALL) begin
          sclk_nx = 1'b0;
          sreg_nx = {sreg[6:0], 1'b0};
          mosi_nx = sreg[6];
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_tx_byte.sv
// Drives four transmitters (HALF 5/2/8 MSB-first, HALF 5 LSB-first) against a cycle-count model
// and a sys_clk-domain mode-0 receiver that scores each byte at tx_done.
module tb_spi_tx_byte;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       en_tx   [4];
  logic [7:0] tx_data [4];
  logic       spi_sclk[4];
  logic       spi_mosi[4];
  logic       tx_busy [4];
  logic       tx_done [4];

  int n_tests = 0;
  int n_fail  = 0;
  int pending [4];

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : gi
    localparam int H = (g == 1) ? 2 : (g == 2) ? 8 : 5;
    localparam bit L = (g == 3);

    spi_tx_byte #(.HALF(H), .LSB_FIRST(L)) u_dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .en_tx    (en_tx[g]),
      .tx_data  (tx_data[g]),
      .spi_sclk (spi_sclk[g]),
      .spi_mosi (spi_mosi[g]),
      .tx_busy  (tx_busy[g]),
      .tx_done  (tx_done[g])
    );

    logic [7:0] exp_q[$];
    int         mc;
    bit         done_exp;
    logic [7:0] rx;
    int         nrise;
    logic       prev_sclk;

    // Bit order seen on the wire, packed first-bit-in-MSB.
    function automatic logic [7:0] seq_of(input logic [7:0] d);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = d[7-i];
      return L ? r : d;
    endfunction

    // Model: a frame occupies 16*H busy cycles, done follows in the next one.
    always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        mc       = 0;
        done_exp = 1'b0;
        exp_q.delete();
      end else begin
        done_exp = (mc == 1);
        if (mc != 0) mc--;
        else if (en_tx[g]) begin
          mc = 16 * H;
          exp_q.push_back(seq_of(tx_data[g]));
        end
      end
    end

    always @(negedge sys_clk) begin
      pending[g] = exp_q.size();
      if (!sys_rst_n) begin
        check($sformatf("rst_outs%0d", g),
              int'({spi_sclk[g], spi_mosi[g], tx_busy[g], tx_done[g]}), 0);
        nrise     = 0;
        rx        = '0;
        prev_sclk = 1'b0;
      end else begin
        if (spi_sclk[g] && !prev_sclk) begin
          rx = {rx[6:0], spi_mosi[g]};
          nrise++;
        end
        prev_sclk = spi_sclk[g];
        check($sformatf("busy%0d", g), int'(tx_busy[g]), int'(mc != 0));
        check($sformatf("done%0d", g), int'(tx_done[g]), int'(done_exp));
        if (mc == 0) check($sformatf("idle_lines%0d", g), int'({spi_sclk[g], spi_mosi[g]}), 0);
        if (tx_done[g]) begin
          if (exp_q.size() == 0) check($sformatf("done_unexpected%0d", g), 1, 0);
          else check($sformatf("byte%0d", g), int'(rx), int'(exp_q.pop_front()));
          check($sformatf("rises%0d", g), nrise, 8);
          nrise = 0;
        end
      end
    end
  end

  task automatic send(input int g, input logic [7:0] d);
    en_tx[g]   = 1'b1;
    tx_data[g] = d;
    @(posedge sys_clk);
    #1;
    en_tx[g]   = 1'b0;
    tx_data[g] = 8'($urandom);
  endtask

  task automatic wait_done(input int g, input int budget, output int n);
    n = 0;
    while (tx_done[g] !== 1'b1 && n < budget) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    if (tx_done[g] !== 1'b1) check($sformatf("timeout%0d", g), 0, 1);
  endtask

  task automatic stream(input int g, input int h, input int count, input bit rnd);
    int         n;
    logic [7:0] d;
    for (int b = 0; b < count; b++) begin
      d = rnd ? 8'($urandom) : 8'(b);
      send(g, d);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 16 * h - 4)) @(posedge sys_clk);
        #1;
        send(g, 8'($urandom));
      end
      wait_done(g, 40 * h, n);
      repeat ($urandom_range(0, 2)) begin
        @(posedge sys_clk);
        #1;
      end
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4; i++) begin
      en_tx[i]   = 1'b0;
      tx_data[i] = 8'h00;
    end
    #2 sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    // Single byte, frame latency from acceptance to done.
    send(0, 8'hA5);
    wait_done(0, 200, n);
    check("lat_a5", n, 80);
    @(posedge sys_clk);
    #1;

    // Request mid-frame with different data is ignored.
    send(0, 8'h3C);
    repeat (29) @(posedge sys_clk);
    #1;
    send(0, 8'hFF);
    wait_done(0, 200, n);
    @(posedge sys_clk);
    #1;

    // Back-to-back: new request in the done cycle.
    send(0, 8'h7E);
    wait_done(0, 200, n);
    send(0, 8'h81);
    wait_done(0, 200, n);
    check("lat_b2b", n, 80);
    @(posedge sys_clk);
    #1;

    // Reset mid-frame, then a clean frame.
    send(0, 8'hC3);
    repeat (42) @(posedge sys_clk);
    #1 sys_rst_n = 1'b0;
    #1;
    check("rst_async_busy", int'(tx_busy[0]), 0);
    check("rst_async_sclk_mosi", int'({spi_sclk[0], spi_mosi[0]}), 0);
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    send(0, 8'h5A);
    wait_done(0, 200, n);
    check("lat_after_rst", n, 80);

    // LSB-first instance.
    send(3, 8'h01);
    wait_done(3, 200, n);
    check("lat_lsb", n, 80);
    @(posedge sys_clk);
    #1;

    // Loopback sweep of all byte values on three clock rates, random bytes on LSB-first.
    fork
      stream(0, 5, 256, 1'b0);
      stream(1, 2, 256, 1'b0);
      stream(2, 8, 256, 1'b0);
      stream(3, 5, 64, 1'b1);
    join

    repeat (4) @(posedge sys_clk);
    #1;
    for (int i = 0; i < 4; i++) check($sformatf("pending%0d", i), pending[i], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
